// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO-buffered AXI-Stream input and a runtime frame format.
// Optional CTS flow control is enabled with `define UART_TX_CTS_EN.
module uart_tx_fifo #(
   parameter int MAX_DATA_BITS   = 9,
   parameter int COUNTER_BITS    = 16,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [COUNTER_BITS-1:0]    cfg_counter_div,
   input  logic [3:0]                 cfg_data_bits,
   input  logic [1:0]                 cfg_parity,
   input  logic                       cfg_stop2,
   input  logic                       cts_n,
   input  logic [MAX_DATA_BITS-1:0]   axis_data,
   input  logic                       axis_valid,
   output logic                       axis_ready,
   output logic                       txd,
   output logic                       busy,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_used
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int                       DEPTH      = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
   localparam logic [FIFO_DEPTH_LOG2:0] ONE_COUNT  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [3:0]               MAX_N      = 4'(MAX_DATA_BITS);
   localparam logic [COUNTER_BITS-1:0]  DIV_ONE    = {{(COUNTER_BITS-1){1'b0}}, 1'b1};
   localparam logic [COUNTER_BITS-1:0]  DIV_ZERO   = {COUNTER_BITS{1'b0}};

   // Parity over the low n data bits; mode 01 even, 10 odd, 11 mark.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d,
                                        input logic [3:0] n,
                                        input logic [1:0] mode);
      logic x;
      x = 1'b0;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < int'(n)) x = x ^ d[i];
         else             x = x;
      end
      case (mode)
         2'b01:   return x;
         2'b10:   return ~x;
         default: return 1'b1;
      endcase
   endfunction

   logic [MAX_DATA_BITS-1:0]   mem_r [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
   state_t                     state_r, state_nxt;
   logic [COUNTER_BITS-1:0]    div_cnt_r, div_nxt;
   logic [3:0]                 bit_cnt_r, bit_nxt;
   logic [MAX_DATA_BITS-1:0]   shreg_r, sh_nxt;
   logic [3:0]                 nbits_r;
   logic                       par_en_r, par_bit_r, stop2_r;
   logic                       txd_nxt, push_s, pop_s, cts_ok_s, can_start_s, bit_end_s;
   logic [3:0]                 cfg_bits_s;
   logic [MAX_DATA_BITS-1:0]   head_s;

`ifdef UART_TX_CTS_EN
   logic [1:0] cts_sync_r;

   // Two-flop synchroniser for the asynchronous clear-to-send input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cts_sync_r <= 2'b11;
      else     cts_sync_r <= {cts_sync_r[0], cts_n};
   end
   assign cts_ok_s = ~cts_sync_r[1];
`else
   logic unused_cts;
   assign unused_cts = cts_n;
   assign cts_ok_s   = 1'b1;
`endif

   assign axis_ready  = (fifo_used != FULL_COUNT);
   assign busy        = (state_r != IDLE) || (fifo_used != {(FIFO_DEPTH_LOG2+1){1'b0}});
   assign push_s      = axis_valid && axis_ready;
   assign head_s      = mem_r[rd_ptr_r];
   assign can_start_s = (fifo_used != {(FIFO_DEPTH_LOG2+1){1'b0}}) && cts_ok_s;
   assign bit_end_s   = (div_cnt_r == DIV_ZERO);
   assign cfg_bits_s  = (cfg_data_bits < 4'd5)  ? 4'd5  :
                        (cfg_data_bits > MAX_N) ? MAX_N : cfg_data_bits;

   // FIFO storage; contents need no reset because fifo_used gates every read.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= axis_data;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r  <= {FIFO_DEPTH_LOG2{1'b0}};
         rd_ptr_r  <= {FIFO_DEPTH_LOG2{1'b0}};
         fifo_used <= {(FIFO_DEPTH_LOG2+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   fifo_used <= fifo_used + ONE_COUNT;
            2'b01:   fifo_used <= fifo_used - ONE_COUNT;
            default: fifo_used <= fifo_used;
         endcase
      end
   end

   // Frame FSM: next state, divider, bit pointer and the value txd takes next cycle.
   always_comb begin
      state_nxt = state_r;
      div_nxt   = div_cnt_r - DIV_ONE;
      bit_nxt   = bit_cnt_r;
      sh_nxt    = shreg_r;
      txd_nxt   = txd;
      pop_s     = 1'b0;
      case (state_r)
         IDLE: begin
            div_nxt = cfg_counter_div;
            if (can_start_s) begin
               pop_s     = 1'b1;
               state_nxt = START;
               sh_nxt    = head_s;
               txd_nxt   = 1'b0;
            end else begin
               txd_nxt   = 1'b1;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_nxt = DATA;
               div_nxt   = cfg_counter_div;
               bit_nxt   = 4'd0;
               txd_nxt   = shreg_r[0];
            end else begin
               txd_nxt   = 1'b0;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               div_nxt = cfg_counter_div;
               if (bit_cnt_r == nbits_r - 4'd1) begin
                  bit_nxt = 4'd0;
                  if (par_en_r) begin
                     state_nxt = PARITY;
                     txd_nxt   = par_bit_r;
                  end else begin
                     state_nxt = STOP;
                     txd_nxt   = 1'b1;
                  end
               end else begin
                  bit_nxt = bit_cnt_r + 4'd1;
                  sh_nxt  = shreg_r >> 1;
                  txd_nxt = shreg_r[1];
               end
            end else begin
               txd_nxt = txd;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               state_nxt = STOP;
               div_nxt   = cfg_counter_div;
               bit_nxt   = 4'd0;
               txd_nxt   = 1'b1;
            end else begin
               txd_nxt   = txd;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               div_nxt = cfg_counter_div;
               if (stop2_r && (bit_cnt_r == 4'd0)) begin
                  bit_nxt = 4'd1;
                  txd_nxt = 1'b1;
               end else if (can_start_s) begin
                  // Next word starts with no idle gap after the stop bit.
                  pop_s     = 1'b1;
                  state_nxt = START;
                  sh_nxt    = head_s;
                  txd_nxt   = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  txd_nxt   = 1'b1;
               end
            end else begin
               txd_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
         end
      endcase
   end

   // FSM and datapath registers; frame format is captured with the popped word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         div_cnt_r <= DIV_ZERO;
         bit_cnt_r <= 4'd0;
         shreg_r   <= {MAX_DATA_BITS{1'b0}};
         txd       <= 1'b1;
         nbits_r   <= 4'd5;
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
         stop2_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         div_cnt_r <= div_nxt;
         bit_cnt_r <= bit_nxt;
         shreg_r   <= sh_nxt;
         txd       <= txd_nxt;
         if (pop_s) begin
            nbits_r   <= cfg_bits_s;
            par_en_r  <= (cfg_parity != 2'b00);
            par_bit_r <= calc_parity(head_s, cfg_bits_s, cfg_parity);
            stop2_r   <= cfg_stop2;
         end
      end
   end

endmodule
